// File: rtl/day1.sv
// 2:1 operand mux with a combinational result and a
// registered copy of the result and select.
module day1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_q_o,
  output logic             sel_q_o
);

  // select a when sel is high, else b; follows inputs even in reset
  always_comb begin
    y_o = b_i;
    unique case (1'b1)
      sel_i:   y_o = a_i;
      default: y_o = b_i;
    endcase
  end

  // capture result and select every edge; reset clears both at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q_o   <= '0;
      sel_q_o <= 1'b0;
    end else begin
      y_q_o   <= y_o;
      sel_q_o <= sel_i;
    end
  end

  // an unknown select makes the result meaningless outside reset
  sel_known_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(sel_i)
  ) else $error("sel_i is X/Z out of reset");

endmodule

// File: tb/tb_day1.sv
// Bench for day1: literal checks plus a random run
// compared every cycle against a history-based model.
module tb_day1;

  logic       clk;
  logic       clk_en;
  logic       rst_ni;
  logic [7:0] a;
  logic [7:0] b;
  logic       sel;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       sel_q;

  int n_chk;
  int n_pass;
  bit chk_en;

  day1 #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .a_i     (a),
    .b_i     (b),
    .sel_i   (sel),
    .y_o     (y),
    .y_q_o   (y_q),
    .sel_q_o (sel_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // model: list of values the register must have captured since reset
  logic [7:0] cap_y[$];
  bit         cap_s[$];

  always @(posedge clk) begin
    if (rst_ni) begin
      cap_y.push_back(sel ? a : b);
      cap_s.push_back(sel);
    end
  end

  always @(negedge rst_ni) begin
    cap_y.delete();
    cap_s.delete();
  end

  function automatic logic [7:0] exp_yq();
    return (cap_y.size() == 0) ? 8'h00 : cap_y[cap_y.size()-1];
  endfunction

  function automatic logic exp_sq();
    return (cap_s.size() == 0) ? 1'b0 : cap_s[cap_s.size()-1];
  endfunction

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
  endtask

  // per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_y", y, sel ? a : b);
      chk("cyc_yq", y_q, exp_yq());
      chk("cyc_sq", {7'd0, sel_q}, {7'd0, exp_sq()});
    end
  end

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      a   = 8'($urandom_range(0, 8'hFF));
      b   = 8'($urandom_range(0, 8'hFF));
      sel = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    chk_en = 1'b0;
    clk_en = 1'b0;
    rst_ni = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    sel    = 1'b0;
    #1;
    chk("rst_yq", y_q, 8'h00);
    chk("rst_sq", {7'd0, sel_q}, 8'h00);

    // combinational select, no clock running
    a = 8'hA5; b = 8'h3C; sel = 1'b1; #1;
    chk("comb_a", y, 8'hA5);
    sel = 1'b0; #1;
    chk("comb_b", y, 8'h3C);

    // extremes
    a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      sel = ~sel; #1;
      chk("ext_tog", y, sel ? 8'hFF : 8'h00);
    end
    a = 8'h5A; b = 8'h5A;
    sel = 1'b0; #1;
    chk("eq_s0", y, 8'h5A);
    sel = 1'b1; #1;
    chk("eq_s1", y, 8'h5A);

    // random sweep, simultaneous changes
    for (int i = 0; i < 12; i++) begin
      a   = 8'($urandom_range(0, 8'hFF));
      b   = 8'($urandom_range(0, 8'hFF));
      sel = 1'($urandom_range(0, 1));
      #5;
      chk("sweep", y, sel ? a : b);
    end
    chk("hold_yq", y_q, 8'h00);

    // release reset mid-cycle
    clk_en = 1'b1;
    sel = 1'b1; a = 8'h77; b = 8'h01;
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    #1;
    chk("rel_hold", y_q, 8'h00);
    @(posedge clk);
    #1;
    chk("rel_cap", y_q, 8'h77);
    chk("rel_sq", {7'd0, sel_q}, 8'h01);

    // registered path
    @(negedge clk);
    a = 8'h12; b = 8'h34; sel = 1'b0;
    @(posedge clk);
    #1;
    chk("reg_n", y_q, 8'h34);
    chk("reg_n_sq", {7'd0, sel_q}, 8'h00);
    sel = 1'b1;
    @(posedge clk);
    #1;
    chk("reg_n1", y_q, 8'h12);
    chk("reg_n1_sq", {7'd0, sel_q}, 8'h01);

    // random run with per-cycle model compare
    chk_en = 1'b1;
    rand_cycles(200);

    // async reset mid-stream
    @(negedge clk);
    #1;
    a = 8'hFF; b = 8'h00; sel = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst", y_q, 8'hFF);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_yq", y_q, 8'h00);
    chk("arst_sq", {7'd0, sel_q}, 8'h00);
    a = 8'h66; #1;
    chk("arst_y", y, 8'h66);
    rand_cycles(5);
    chk("arst_held", y_q, 8'h00);
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    rand_cycles(200);

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
